// File: rtl/stream_parity.sv
// stream_parity: frame-level parity generator/checker on a valid/ready stream.
// Words of WIDTH bits are XOR-folded into one running parity bit. A frame
// closes on in_last or when MAX_WORDS words have been taken. The result
// (parity, word count, truncation flag) is then held on the output port until
// the consumer takes it.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACCUM | accepting beats, folding parity into acc_q, counting words
// HOLD  | result presented on out_*, input stalled until out_ready
module stream_parity #(
  parameter int WIDTH     = 4,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             odd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_trunc_q, out_trunc_d;

  logic             beat;
  logic             first_beat;
  logic             mode_eff;
  logic             par_next;
  logic [CNT_W-1:0] count_inc;
  logic             close_frame;

  // Ready comes from registered state only, so no path from in_valid/out_ready.
  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign out_count  = out_count_q;
  assign out_trunc  = out_trunc_q;

  // Next-state and result logic; in_data/in_last are only looked at on an
  // accepted beat so X on an idle bus cannot leak into state.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    out_count_d  = out_count_q;
    out_trunc_d  = out_trunc_q;
    beat         = 1'b0;
    first_beat   = 1'b0;
    mode_eff     = mode_q;
    par_next     = acc_q;
    count_inc    = count_q;
    close_frame  = 1'b0;

    case (state_q)
      ACCUM: begin
        beat = in_valid;
        if (beat) begin
          first_beat  = (count_q == '0);
          mode_eff    = first_beat ? odd_mode : mode_q;
          par_next    = acc_q ^ (^in_data);
          count_inc   = count_q + 1'b1;
          close_frame = in_last | (count_inc == MAX_CNT);
          if (first_beat) begin
            mode_d = odd_mode;
          end
          if (close_frame) begin
            out_parity_d = par_next ^ mode_eff;
            out_count_d  = count_inc;
            out_trunc_d  = ~in_last;
            out_valid_d  = 1'b1;
            state_d      = HOLD;
            acc_d        = 1'b0;
            count_d      = '0;
          end else begin
            acc_d   = par_next;
            count_d = count_inc;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ACCUM;
      acc_q        <= 1'b0;
      count_q      <= '0;
      mode_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      out_trunc_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
      out_trunc_q  <= out_trunc_d;
    end
  end

endmodule

// File: doc/stream_parity.md
Name: stream_parity

Overview:
- Parametrised, sequential successor to the team's 4-bit combinational parity (XOR) block.
- Accumulates parity over a frame of WIDTH-bit words arriving on a valid/ready stream, with even/odd mode selection.
- Reports parity, word count and a truncation flag on a valid/ready result port.
- Used as a frame-level parity generator/checker in front of serial links and memory write paths.

Parameters:
- WIDTH, 4, bits per input word.
- MAX_WORDS, 16, maximum words per frame (>=1); the frame is force-closed when this count is reached.
- CNT_W, $clog2(MAX_WORDS+1), derived width of the word counter; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on the first accepted beat of each frame.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  data word.
- in_last  input  1  final word of frame.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- out_parity  output  1  frame parity bit.
- out_count  output  CNT_W  number of words in the closed frame.
- out_trunc  output  1  frame closed by MAX_WORDS without in_last.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n).
- All state is updated only on the rising edge of clk.
- States: ACCUM, HOLD.
- Reset (reset_n=0 at a clk edge):
  - state=ACCUM; acc=0; count=0; mode_q=0.
  - out_valid=0, out_parity=0, out_count=0, out_trunc=0.
  - in_ready=1 from the first cycle after reset.
- in_ready = (state==ACCUM). It is decoded from registered state only and has no combinational path from in_valid or out_ready.
- Beat accepted when in_valid & in_ready. In ACCUM:
  - A cycle without an accepted beat leaves all state unchanged. in_data and in_last are ignored when in_valid=0; X values there must not propagate.
  - On the first beat of a frame (count==0), mode_q <= odd_mode. odd_mode changes mid-frame have no effect.
  - On each accepted beat: acc <= acc ^ (^in_data); count <= count+1.
  - The frame closes on the accepted beat where in_last=1 or count+1==MAX_WORDS. On that edge:
    - out_parity <= acc ^ (^in_data) ^ mode_eff, where mode_eff is odd_mode if this is the first beat, else mode_q.
    - out_count <= count+1.
    - out_trunc <= ~in_last.
    - out_valid <= 1; state <= HOLD.
    - acc and count are cleared to 0.
  - Latency: result is visible the cycle after the closing beat.
- Parity definition: even mode gives XOR of all frame bits, so data plus parity bit has even weight. Odd mode gives the inverse. Example: the single word 0001 yields 1 in even mode and 0 in odd mode.
- HOLD:
  - in_ready=0. out_parity, out_count and out_trunc are held stable while out_valid=1 & out_ready=0.
  - On out_ready=1: out_valid <= 0 and state <= ACCUM. The next beat can be accepted the following cycle, so there is no same-cycle bypass. out_parity, out_count and out_trunc keep their last values after out_valid drops.
- MAX_WORDS=1: every beat closes a frame. out_trunc = ~in_last.
- Counter never exceeds MAX_WORDS; no wrap-around is possible.
- Reset mid-frame or in HOLD discards the partial frame or pending result. No result is emitted.

Test Plan (WIDTH=4, MAX_WORDS=4 unless stated):
1. Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_parity=0, out_count=0, out_trunc=0, no beat counted; in_ready=1 on the first cycle after reset_n=1.
2. Single beat 0001, in_last=1, odd_mode=0 -> next cycle out_valid=1, out_parity=1, out_count=1, out_trunc=0, in_ready=0. Repeat with odd_mode=1 -> out_parity=0.
3. Frame 0111, 1011, 0011(last), even -> out_parity=0, out_count=3. Same frame with odd_mode=1 on beat 1 and odd_mode=0 on beats 2-3 -> out_parity=1.
4. Truncation: beats 0001 x4 with no in_last -> out_parity=0, out_count=4, out_trunc=1. A 5th beat 1111 held valid stalls (in_ready=0) until out_ready. Then a new frame starts and 1111(last) yields parity 0, count 1, trunc 0.
5. Backpressure: hold out_ready=0 for 5 cycles after a result -> outputs stable, in_ready=0, no beats accepted. Pulse out_ready=1 -> out_valid=0 next cycle and in_ready=1.
6. Reset mid-frame: accept 0001 and 0011, assert reset_n=0 for 1 cycle, then send 0100(last) -> out_parity=1, out_count=1.
